// File: rtl/csr_regfile.sv
// Machine-mode CSR file at the write-back end of the pipeline.
// Stores the M-mode CSRs, serves combinational reads with same-cycle write
// bypass, runs the mcycle/minstret counters and applies trap/mret updates.
module csr_regfile #(
  parameter int              XLEN    = 64,
  parameter logic [XLEN-1:0] HART_ID = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_wreg_i,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic [11:0]     csr_raddr_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            stall_i,
  input  logic            retire_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_global_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  // mtvec keeps its mode bits at zero, mepc stays 2-byte aligned.
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-1){1'b1}}, 1'b0};

  // Only MIE and MPIE are real state; MPP is hard-wired to M-mode.
  logic            mstatus_mie_q;
  logic            mstatus_mpie_q;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mcycle_q;
  logic [XLEN-1:0] minstret_q;

  logic            wr_en;
  logic            wr_writable;
  logic [XLEN-1:0] wr_legal;
  logic [XLEN-1:0] rd_stored;
  logic            rd_impl;
  logic            bypass;

  function automatic logic [XLEN-1:0] mstatus_view(input logic mie, input logic mpie);
    logic [XLEN-1:0] v;
    v        = '0;
    v[12:11] = 2'b11;
    v[7]     = mpie;
    v[3]     = mie;
    return v;
  endfunction

  assign wr_en = csr_wreg_i & ~stall_i;

  // Legalise the write data for the target CSR and flag writable targets.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_legal    = csr_wdata_i;
    wr_writable = 1'b1;
    case (csr_waddr_i)
      ADDR_MSTATUS:  wr_legal = mstatus_view(csr_wdata_i[3], csr_wdata_i[7]);
      ADDR_MTVEC:    wr_legal = csr_wdata_i & MTVEC_MASK;
      ADDR_MEPC:     wr_legal = csr_wdata_i & MEPC_MASK;
      ADDR_MIE, ADDR_MSCRATCH, ADDR_MCAUSE, ADDR_MCYCLE, ADDR_MINSTRET: wr_legal = csr_wdata_i;
      default:       wr_writable = 1'b0;
    endcase
  end

  // Select the stored value for the read address and flag unimplemented CSRs.
  always_comb begin
    rd_stored = '0;
    rd_impl   = 1'b1;
    case (csr_raddr_i)
      ADDR_MSTATUS:  rd_stored = mstatus_view(mstatus_mie_q, mstatus_mpie_q);
      ADDR_MIE:      rd_stored = mie_q;
      ADDR_MTVEC:    rd_stored = mtvec_q;
      ADDR_MSCRATCH: rd_stored = mscratch_q;
      ADDR_MEPC:     rd_stored = mepc_q;
      ADDR_MCAUSE:   rd_stored = mcause_q;
      ADDR_MCYCLE:   rd_stored = mcycle_q;
      ADDR_MINSTRET: rd_stored = minstret_q;
      ADDR_MHARTID:  rd_stored = HART_ID;
      default:       rd_impl   = 1'b0;
    endcase
  end

  // A software write in flight to the same CSR is forwarded to decode.
  assign bypass        = wr_en & wr_writable & (csr_waddr_i == csr_raddr_i);
  assign csr_rdata_o   = bypass ? wr_legal : rd_stored;
  assign csr_illegal_o = ~rd_impl;

  // mstatus: trap beats mret beats software write.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (trap_valid_i) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (wr_en && csr_waddr_i == ADDR_MSTATUS) begin
      mstatus_mie_q  <= csr_wdata_i[3];
      mstatus_mpie_q <= csr_wdata_i[7];
    end
  end

  // mepc/mcause: a trap overwrites both and drops any concurrent software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (trap_valid_i) begin
      mepc_q   <= trap_pc_i & MEPC_MASK;
      mcause_q <= trap_cause_i;
    end else begin
      if (wr_en && csr_waddr_i == ADDR_MEPC)   mepc_q   <= wr_legal;
      if (wr_en && csr_waddr_i == ADDR_MCAUSE) mcause_q <= wr_legal;
    end
  end

  // Plain software-only CSRs; these still accept writes during a trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else begin
      if (wr_en && csr_waddr_i == ADDR_MIE)      mie_q      <= wr_legal;
      if (wr_en && csr_waddr_i == ADDR_MTVEC)    mtvec_q    <= wr_legal;
      if (wr_en && csr_waddr_i == ADDR_MSCRATCH) mscratch_q <= wr_legal;
    end
  end

  // Counters: a software write replaces that cycle's increment; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en && csr_waddr_i == ADDR_MCYCLE) mcycle_q <= wr_legal;
      else                                     mcycle_q <= mcycle_q + 1'b1;
      if (wr_en && csr_waddr_i == ADDR_MINSTRET) minstret_q <= wr_legal;
      else if (retire_i && !stall_i)             minstret_q <= minstret_q + 1'b1;
    end
  end

  assign mtvec_o      = mtvec_q;
  assign mepc_o       = mepc_q;
  assign mie_global_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed scenarios plus a randomized
// run compared against a behavioural CSR model.
`timescale 1ns/1ps
module tb_csr_regfile;

  localparam int          XLEN = 64;
  localparam logic [63:0] HART = 64'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_wreg_i;
  logic [11:0] csr_waddr_i;
  logic [63:0] csr_wdata_i;
  logic [11:0] csr_raddr_i;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        stall_i;
  logic        retire_i;
  logic        trap_valid_i;
  logic [63:0] trap_cause_i;
  logic [63:0] trap_pc_i;
  logic        mret_i;
  logic [63:0] mtvec_o;
  logic [63:0] mepc_o;
  logic        mie_global_o;

  csr_regfile #(.XLEN(XLEN), .HART_ID(HART)) dut (
    .clk(clk), .rst(rst),
    .csr_wreg_i(csr_wreg_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .stall_i(stall_i), .retire_i(retire_i),
    .trap_valid_i(trap_valid_i), .trap_cause_i(trap_cause_i), .trap_pc_i(trap_pc_i),
    .mret_i(mret_i), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_global_o(mie_global_o)
  );

  always #50 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [11:0] ADDRS [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                        12'h342, 12'hB00, 12'hB02, 12'hF14};
  localparam logic [11:0] POOL [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                        12'h342, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'h301};

  // Reference model: architectural CSR values as software reads them.
  logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret;

  function automatic bit m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02, 12'hF14};
  endfunction

  function automatic bit m_writable(input logic [11:0] a);
    return m_impl(a) && a != 12'hF14;
  endfunction

  function automatic logic [63:0] m_legal(input logic [11:0] a, input logic [63:0] d);
    case (a)
      12'h300: return (d & 64'h88) | 64'h1800;
      12'h305: return d & ~64'h3;
      12'h341: return d & ~64'h1;
      default: return d;
    endcase
  endfunction

  function automatic logic [63:0] m_stored(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      12'hF14: return HART;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] exp_rdata();
    if (csr_wreg_i && !stall_i && csr_waddr_i == csr_raddr_i && m_writable(csr_waddr_i))
      return m_legal(csr_waddr_i, csr_wdata_i);
    return m_stored(csr_raddr_i);
  endfunction

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic tick();
    logic [63:0] n_mstatus, n_mie, n_mtvec, n_mscratch, n_mepc, n_mcause, n_mcycle, n_minstret;
    n_mstatus = m_mstatus; n_mie = m_mie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
    n_mepc = m_mepc; n_mcause = m_mcause; n_mcycle = m_mcycle; n_minstret = m_minstret;
    if (rst) begin
      n_mstatus = 64'h1800; n_mie = 0; n_mtvec = 0; n_mscratch = 0;
      n_mepc = 0; n_mcause = 0; n_mcycle = 0; n_minstret = 0;
    end else begin
      n_mcycle = m_mcycle + 64'd1;
      if (retire_i && !stall_i) n_minstret = m_minstret + 64'd1;
      if (csr_wreg_i && !stall_i) begin
        case (csr_waddr_i)
          12'h300: n_mstatus  = m_legal(csr_waddr_i, csr_wdata_i);
          12'h304: n_mie      = csr_wdata_i;
          12'h305: n_mtvec    = m_legal(csr_waddr_i, csr_wdata_i);
          12'h340: n_mscratch = csr_wdata_i;
          12'h341: n_mepc     = m_legal(csr_waddr_i, csr_wdata_i);
          12'h342: n_mcause   = csr_wdata_i;
          12'hB00: n_mcycle   = csr_wdata_i;
          12'hB02: n_minstret = csr_wdata_i;
          default: ;
        endcase
      end
      if (mret_i && !trap_valid_i) n_mstatus = 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
      if (trap_valid_i) begin
        n_mepc    = trap_pc_i & ~64'h1;
        n_mcause  = trap_cause_i;
        n_mstatus = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
      end
    end
    @(posedge clk);
    m_mstatus = n_mstatus; m_mie = n_mie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
    m_mepc = n_mepc; m_mcause = n_mcause; m_mcycle = n_mcycle; m_minstret = n_minstret;
    #1;
  endtask

  task automatic idle();
    rst = 0; csr_wreg_i = 0; csr_waddr_i = 0; csr_wdata_i = 0; stall_i = 0;
    retire_i = 0; trap_valid_i = 0; trap_cause_i = 0; trap_pc_i = 0; mret_i = 0;
  endtask

  task automatic read_at(input logic [11:0] a);
    csr_raddr_i = a;
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; csr_raddr_i = 12'h300;
    tick(); tick();
    rst = 0;
    read_at(12'h300);
    n_tests++; if (csr_rdata_o !== 64'h1800) begin n_fail++; $display("FAIL reset_mstatus: got %h expected %h", csr_rdata_o, 64'h1800); end
    read_at(12'hB00);
    n_tests++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL reset_mcycle: got %h expected 0", csr_rdata_o); end
    n_tests++; if (mtvec_o !== 64'h0 || mepc_o !== 64'h0 || mie_global_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: mtvec %h mepc %h mie %b expected all 0", mtvec_o, mepc_o, mie_global_o); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      read_at(12'hB00);
      n_tests++; if (csr_rdata_o !== 64'(i)) begin n_fail++; $display("FAIL mcycle_count: got %h expected %h", csr_rdata_o, 64'(i)); end
    end
  endtask

  task automatic test_bypass();
    idle();
    csr_wreg_i = 1; csr_waddr_i = 12'h340; csr_wdata_i = 64'hDEAD_BEEF;
    read_at(12'h340);
    n_tests++; if (csr_rdata_o !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_mscratch: got %h expected %h", csr_rdata_o, 64'hDEAD_BEEF); end
    tick(); idle();
    read_at(12'h340);
    n_tests++; if (csr_rdata_o !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL stored_mscratch: got %h expected %h", csr_rdata_o, 64'hDEAD_BEEF); end
    csr_wreg_i = 1; csr_waddr_i = 12'h305; csr_wdata_i = 64'h1003;
    tick(); idle();
    read_at(12'h305);
    n_tests++; if (csr_rdata_o !== 64'h1000) begin n_fail++; $display("FAIL mtvec_mask: got %h expected %h", csr_rdata_o, 64'h1000); end
    n_tests++; if (mtvec_o !== 64'h1000) begin n_fail++; $display("FAIL mtvec_o: got %h expected %h", mtvec_o, 64'h1000); end
  endtask

  task automatic test_stall();
    logic [63:0] base;
    idle();
    read_at(12'hB02);
    base = m_minstret;
    csr_wreg_i = 1; stall_i = 1; csr_waddr_i = 12'h340; csr_wdata_i = 64'd5;
    read_at(12'h340);
    n_tests++; if (csr_rdata_o !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_no_bypass: got %h expected %h", csr_rdata_o, 64'hDEAD_BEEF); end
    tick(); idle();
    read_at(12'h340);
    n_tests++; if (csr_rdata_o !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_write: got %h expected %h", csr_rdata_o, 64'hDEAD_BEEF); end
    retire_i = 1; stall_i = 1;
    tick(); idle();
    read_at(12'hB02);
    n_tests++; if (csr_rdata_o !== base) begin n_fail++; $display("FAIL stall_minstret: got %h expected %h", csr_rdata_o, base); end
    retire_i = 1;
    tick(); tick(); tick();
    idle();
    read_at(12'hB02);
    n_tests++; if (csr_rdata_o !== base + 64'd3) begin n_fail++; $display("FAIL minstret_count: got %h expected %h", csr_rdata_o, base + 64'd3); end
  endtask

  task automatic test_trap_mret();
    idle();
    csr_wreg_i = 1; csr_waddr_i = 12'h300; csr_wdata_i = 64'h8;
    tick(); idle();
    read_at(12'h300);
    n_tests++; if (csr_rdata_o !== 64'h1808 || mie_global_o !== 1'b1) begin
      n_fail++; $display("FAIL mstatus_write: got %h/%b expected %h/1", csr_rdata_o, mie_global_o, 64'h1808); end
    trap_valid_i = 1; trap_cause_i = 64'h8000_0000_0000_0007; trap_pc_i = 64'h8000_0105;
    csr_wreg_i = 1; csr_waddr_i = 12'h341; csr_wdata_i = 64'h44;
    tick(); idle();
    read_at(12'h341);
    n_tests++; if (csr_rdata_o !== 64'h8000_0104 || mepc_o !== 64'h8000_0104) begin
      n_fail++; $display("FAIL trap_mepc: got %h/%h expected %h", csr_rdata_o, mepc_o, 64'h8000_0104); end
    read_at(12'h342);
    n_tests++; if (csr_rdata_o !== 64'h8000_0000_0000_0007) begin n_fail++; $display("FAIL trap_mcause: got %h expected %h", csr_rdata_o, 64'h8000_0000_0000_0007); end
    read_at(12'h300);
    n_tests++; if (csr_rdata_o !== 64'h1880 || mie_global_o !== 1'b0) begin
      n_fail++; $display("FAIL trap_mstatus: got %h/%b expected %h/0", csr_rdata_o, mie_global_o, 64'h1880); end
    mret_i = 1;
    tick(); idle();
    read_at(12'h300);
    n_tests++; if (csr_rdata_o !== 64'h1888 || mie_global_o !== 1'b1) begin
      n_fail++; $display("FAIL mret_mstatus: got %h/%b expected %h/1", csr_rdata_o, mie_global_o, 64'h1888); end
    trap_valid_i = 1; mret_i = 1; trap_cause_i = 64'd3; trap_pc_i = 64'h200;
    tick(); idle();
    read_at(12'h300);
    n_tests++; if (csr_rdata_o !== 64'h1880) begin n_fail++; $display("FAIL trap_over_mret: got %h expected %h", csr_rdata_o, 64'h1880); end
  endtask

  task automatic test_counter_wrap();
    idle();
    csr_wreg_i = 1; csr_waddr_i = 12'hB00; csr_wdata_i = '1;
    tick(); idle();
    read_at(12'hB00);
    n_tests++; if (csr_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL mcycle_load: got %h expected all ones", csr_rdata_o); end
    tick();
    read_at(12'hB00);
    n_tests++; if (csr_rdata_o !== 64'h0) begin n_fail++; $display("FAIL mcycle_wrap: got %h expected 0", csr_rdata_o); end
    csr_wreg_i = 1; csr_waddr_i = 12'hB02; csr_wdata_i = 64'd7; retire_i = 1;
    tick(); idle();
    read_at(12'hB02);
    n_tests++; if (csr_rdata_o !== 64'd7) begin n_fail++; $display("FAIL minstret_write_wins: got %h expected 7", csr_rdata_o); end
  endtask

  task automatic test_illegal_hartid();
    idle();
    read_at(12'h7C0);
    n_tests++; if (csr_rdata_o !== 64'h0 || csr_illegal_o !== 1'b1) begin
      n_fail++; $display("FAIL illegal_read: got %h/%b expected 0/1", csr_rdata_o, csr_illegal_o); end
    read_at(12'h300);
    n_tests++; if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL legal_read: illegal got %b expected 0", csr_illegal_o); end
    csr_wreg_i = 1; csr_waddr_i = 12'hF14; csr_wdata_i = 64'd9;
    read_at(12'hF14);
    n_tests++; if (csr_rdata_o !== HART) begin n_fail++; $display("FAIL mhartid_no_bypass: got %h expected %h", csr_rdata_o, HART); end
    tick(); idle();
    read_at(12'hF14);
    n_tests++; if (csr_rdata_o !== HART) begin n_fail++; $display("FAIL mhartid_ro: got %h expected %h", csr_rdata_o, HART); end
  endtask

  task automatic test_reset_during_trap();
    logic [63:0] exp;
    idle();
    csr_wreg_i = 1; csr_waddr_i = 12'h304; csr_wdata_i = 64'hABC; retire_i = 1;
    tick(); idle();
    rst = 1; trap_valid_i = 1; trap_cause_i = 64'd11; trap_pc_i = 64'h1234;
    csr_wreg_i = 1; csr_waddr_i = 12'h340; csr_wdata_i = 64'h77; retire_i = 1;
    tick(); idle();
    foreach (ADDRS[i]) begin
      read_at(ADDRS[i]);
      exp = (ADDRS[i] == 12'h300) ? 64'h1800 : (ADDRS[i] == 12'hF14) ? HART : 64'h0;
      n_tests++; if (csr_rdata_o !== exp) begin n_fail++; $display("FAIL rst_over_trap %h: got %h expected %h", ADDRS[i], csr_rdata_o, exp); end
    end
    n_tests++; if (mtvec_o !== 64'h0 || mepc_o !== 64'h0 || mie_global_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_over_trap_outputs: mtvec %h mepc %h mie %b expected all 0", mtvec_o, mepc_o, mie_global_o); end
  endtask

  task automatic test_random();
    logic [63:0] exp;
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      csr_wreg_i   = $urandom_range(0, 1) == 1;
      csr_waddr_i  = POOL[$urandom_range(0, 10)];
      csr_wdata_i  = {$urandom, $urandom};
      csr_raddr_i  = ($urandom_range(0, 2) == 0) ? csr_waddr_i : POOL[$urandom_range(0, 10)];
      stall_i      = ($urandom_range(0, 3) == 0);
      retire_i     = $urandom_range(0, 1) == 1;
      trap_valid_i = ($urandom_range(0, 19) == 0);
      trap_cause_i = {$urandom, $urandom};
      trap_pc_i    = {$urandom, $urandom};
      mret_i       = ($urandom_range(0, 19) == 0);
      #1;
      exp = exp_rdata();
      n_tests++; if (csr_rdata_o !== exp) begin n_fail++; $display("FAIL rand_rdata c%0d a=%h: got %h expected %h", c, csr_raddr_i, csr_rdata_o, exp); end
      n_tests++; if (csr_illegal_o !== !m_impl(csr_raddr_i)) begin n_fail++; $display("FAIL rand_illegal c%0d a=%h: got %b", c, csr_raddr_i, csr_illegal_o); end
      n_tests++; if (mtvec_o !== m_mtvec || mepc_o !== m_mepc || mie_global_o !== m_mstatus[3]) begin
        n_fail++; $display("FAIL rand_outputs c%0d: mtvec %h/%h mepc %h/%h mie %b/%b", c, mtvec_o, m_mtvec, mepc_o, m_mepc, mie_global_o, m_mstatus[3]); end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    csr_raddr_i = 12'h300;
    test_reset();
    test_bypass();
    test_stall();
    test_trap_mret();
    test_counter_wrap();
    test_illegal_hartid();
    test_reset_during_trap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
